// File: rtl/rtib_core_if.sv
// Signal bundle between the real-time input buffer and its TTL/host side.
interface rtib_core_if #(
    parameter int unsigned ADDR_WIDTH = 10
);
    logic                auto_start;
    logic                flush;
    logic [7:0]          ttl_in;
    logic [7:0]          rise_en;
    logic [7:0]          fall_en;
    logic [63:0]         counter;
    logic                read;
    logic [127:0]        dout;
    logic                valid;
    logic [ADDR_WIDTH:0] count;
    logic                full;
    logic                empty;
    logic                overflow_error;
    logic [127:0]        overflow_error_data;

    modport slave (
        input  auto_start, flush, ttl_in, rise_en, fall_en, counter, read,
        output dout, valid, count, full, empty, overflow_error, overflow_error_data
    );

    modport master (
        output auto_start, flush, ttl_in, rise_en, fall_en, counter, read,
        input  dout, valid, count, full, empty, overflow_error, overflow_error_data
    );
endinterface

// File: rtl/rtib_core.sv
// Real-time input buffer: synchronises 8 TTL inputs, timestamps enabled edges
// and queues {timestamp, 48'h0, edge_mask, state} words for host readout.
module rtib_core #(
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned THRESHOLD  = 1000
) (
    input logic        clk,
    input logic        reset,
    rtib_core_if.slave bus
);
    localparam logic [ADDR_WIDTH:0] THR = (ADDR_WIDTH + 1)'(THRESHOLD);

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    state_e                state_q;
    logic [7:0]            s1_q, s2_q, prev_q;
    logic [63:0]           ts1_q, ts2_q;
    logic                  push_q;
    logic [127:0]          word_q;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_WIDTH:0]   count_q;
    logic                  valid_q;
    logic [127:0]          dout_q;
    logic                  ovf_q;
    logic [127:0]          ovf_data_q;
    logic [127:0]          mem [DEPTH];

    logic [7:0]   edge_mask_d;
    logic         event_d;
    logic [127:0] word_d;
    logic         full_d;
    logic         do_write;
    logic         do_drop;
    logic         do_pop;
    logic         do_fetch;

    always_comb begin
        edge_mask_d = (s2_q & ~prev_q & bus.rise_en) | (~s2_q & prev_q & bus.fall_en);
        event_d     = (|edge_mask_d) && (state_q == RUN) && !bus.flush;
        word_d      = {ts2_q, 48'h0, edge_mask_d, s2_q};
        full_d      = (count_q >= THR);
        // The detected event is staged one cycle; fullness is judged when it reaches the FIFO.
        do_write    = push_q && !full_d && !bus.flush;
        do_drop     = push_q && full_d && !bus.flush;
        do_pop      = valid_q && bus.read && !bus.flush;
        do_fetch    = !valid_q && (count_q != '0) && !bus.flush;
    end

    always_ff @(posedge clk) begin
        if (reset && do_write) begin
            mem[wr_ptr_q] <= word_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            s1_q       <= '0;
            s2_q       <= '0;
            prev_q     <= '0;
            ts1_q      <= '0;
            ts2_q      <= '0;
            push_q     <= 1'b0;
            word_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            dout_q     <= '0;
            ovf_q      <= 1'b0;
            ovf_data_q <= '0;
        end else begin
            s1_q   <= bus.ttl_in;
            s2_q   <= s1_q;
            prev_q <= s2_q;
            ts1_q  <= bus.counter;
            ts2_q  <= ts1_q;

            case (state_q)
                IDLE:    if (bus.auto_start)  state_q <= RUN;
                RUN:     if (!bus.auto_start) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase

            push_q <= event_d;
            word_q <= word_d;
            ovf_q  <= do_drop;
            if (do_drop) begin
                ovf_data_q <= word_q;
            end

            if (bus.flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
                valid_q  <= 1'b0;
            end else begin
                if (do_write) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (do_pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
                case ({do_write, do_pop})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
                if (do_pop) begin
                    valid_q <= 1'b0;
                end else if (do_fetch) begin
                    valid_q <= 1'b1;
                    dout_q  <= mem[rd_ptr_q];
                end
            end
        end
    end

    assign bus.dout                = dout_q;
    assign bus.valid               = valid_q;
    assign bus.count               = count_q;
    assign bus.full                = full_d;
    assign bus.empty               = (count_q == '0);
    assign bus.overflow_error      = ovf_q;
    assign bus.overflow_error_data = ovf_data_q;
endmodule

// File: tb/tb_rtib_core.sv
// Self-checking bench for rtib_core: vector table, directed corner sequences
// and a randomized phase checked against a sample-level event model.
module tb_rtib_core;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 3;
    localparam int unsigned THR   = 4;

    typedef struct {
        logic [7:0] from;
        logic [7:0] to;
        logic [7:0] rise;
        logic [7:0] fall;
        logic [7:0] exp_mask;
    } vec_t;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] cnt   = 64'd100;
    int          n_cmp = 0;
    int          n_err = 0;
    int          ovf_seen = 0;
    int          o0;

    logic          model_on = 1'b0;
    logic [7:0]    mprev = '0;
    logic [127:0]  mq[$];
    logic [63:0]   ts, t0, t1, t2, tsa;
    logic [63:0]   ts3 [6];
    logic [127:0]  ovf_word3;
    vec_t          vecs [6];

    rtib_core_if #(.ADDR_WIDTH(AW)) bus ();

    rtib_core #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .THRESHOLD(THR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cnt <= cnt + 64'd1;
    assign bus.counter = cnt;

    always @(negedge clk) if (bus.overflow_error) ovf_seen++;

    // Reference: each sampled TTL vector is compared with the previous sample.
    always @(posedge clk) begin
        logic [7:0] m;
        if (model_on) begin
            m = (bus.ttl_in & ~mprev & bus.rise_en) | (~bus.ttl_in & mprev & bus.fall_en);
            if (m != 8'h00) mq.push_back({cnt, 48'h0, m, bus.ttl_in});
            mprev = bus.ttl_in;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    function automatic logic [127:0] word(input logic [63:0] t, input logic [7:0] m,
                                          input logic [7:0] s);
        return {t, 48'h0, m, s};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ttl(input logic [7:0] v, output logic [63:0] t);
        @(negedge clk);
        bus.ttl_in = v;
        t = cnt;
    endtask

    task automatic pop_check(input string name, input logic [127:0] exp);
        int unsigned guard = 0;
        @(negedge clk);
        while (!bus.valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check({name, "_valid"}, 128'(bus.valid), 128'(1));
        check(name, bus.dout, exp);
        bus.read = 1'b1;
        @(negedge clk);
        bus.read = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'h00, 8'hFF, 8'h0F, 8'h00, 8'h0F};
        vecs[1] = '{8'hFF, 8'h00, 8'hFF, 8'h3C, 8'h3C};
        vecs[2] = '{8'h0F, 8'hF0, 8'h80, 8'h01, 8'h81};
        vecs[3] = '{8'h55, 8'hAA, 8'h00, 8'h00, 8'h00};
        vecs[4] = '{8'hAA, 8'h55, 8'h55, 8'hAA, 8'hFF};
        vecs[5] = '{8'h33, 8'h33, 8'hFF, 8'hFF, 8'h00};

        bus.auto_start = 1'b0;
        bus.flush      = 1'b0;
        bus.ttl_in     = '0;
        bus.rise_en    = '0;
        bus.fall_en    = '0;
        bus.read       = 1'b0;
        cyc(3);
        check("rst_dout", bus.dout, '0);
        check("rst_valid", 128'(bus.valid), 128'(0));
        check("rst_count", 128'(bus.count), 128'(0));
        check("rst_empty", 128'(bus.empty), 128'(1));
        check("rst_full", 128'(bus.full), 128'(0));
        check("rst_ovf", 128'(bus.overflow_error), 128'(0));
        check("rst_ovf_data", bus.overflow_error_data, '0);
        reset = 1'b1;

        // Single rising edge on channel 0 sampled with counter == 200.
        bus.auto_start = 1'b1;
        bus.rise_en    = 8'h01;
        begin
            int unsigned guard = 0;
            while (cnt != 64'd200 && guard < 500) begin
                @(negedge clk);
                guard++;
            end
        end
        check("t1_counter_reached", cnt, 128'(200));
        bus.ttl_in = 8'h01;
        ts = cnt;
        cyc(3);
        check("t1_count_e2", 128'(bus.count), 128'(0));
        cyc(1);
        check("t1_count_e3", 128'(bus.count), 128'(1));
        check("t1_empty_e3", 128'(bus.empty), 128'(0));
        check("t1_valid_e3", 128'(bus.valid), 128'(0));
        cyc(1);
        check("t1_valid_e4", 128'(bus.valid), 128'(1));
        check("t1_word", bus.dout, word(64'd200, 8'h01, 8'h01));
        bus.read = 1'b1;
        cyc(1);
        bus.read = 1'b0;
        check("t1_valid_after_pop", 128'(bus.valid), 128'(0));
        check("t1_empty_after_pop", 128'(bus.empty), 128'(1));

        for (int i = 0; i < 6; i++) begin
            bus.rise_en = '0;
            bus.fall_en = '0;
            set_ttl(vecs[i].from, ts);
            cyc(5);
            bus.rise_en = vecs[i].rise;
            bus.fall_en = vecs[i].fall;
            cyc(1);
            set_ttl(vecs[i].to, ts);
            cyc(6);
            check($sformatf("vec%0d_count", i), 128'(bus.count),
                  128'(vecs[i].exp_mask != 8'h00));
            if (vecs[i].exp_mask != 8'h00)
                pop_check($sformatf("vec%0d_word", i), word(ts, vecs[i].exp_mask, vecs[i].to));
        end

        // Two opposite transitions ten cycles apart, all channels enabled.
        bus.rise_en = '0;
        bus.fall_en = '0;
        set_ttl(8'h00, ts);
        cyc(5);
        bus.rise_en = 8'hFF;
        bus.fall_en = 8'hFF;
        cyc(1);
        set_ttl(8'hA5, tsa);
        cyc(9);
        set_ttl(8'h00, ts);
        cyc(6);
        check("t2_count", 128'(bus.count), 128'(2));
        pop_check("t2_first", word(tsa, 8'hA5, 8'hA5));
        pop_check("t2_second", word(tsa + 64'd10, 8'hA5, 8'h00));

        // Six events into a threshold-4 buffer without reads.
        o0 = ovf_seen;
        for (int i = 0; i < 6; i++) begin
            set_ttl((i % 2 == 0) ? 8'h01 : 8'h00, ts3[i]);
            cyc(5);
        end
        cyc(4);
        ovf_word3 = word(ts3[5], 8'h01, 8'h00);
        check("t3_count", 128'(bus.count), 128'(4));
        check("t3_full", 128'(bus.full), 128'(1));
        check("t3_ovf_pulses", 128'(ovf_seen - o0), 128'(2));
        check("t3_ovf_data", bus.overflow_error_data, ovf_word3);
        for (int i = 0; i < 4; i++)
            pop_check($sformatf("t3_pop%0d", i),
                      word(ts3[i], 8'h01, (i % 2 == 0) ? 8'h01 : 8'h00));
        cyc(1);
        check("t3_empty", 128'(bus.empty), 128'(1));
        check("t3_not_full", 128'(bus.full), 128'(0));

        // Push and pop landing on the same edge.
        set_ttl(8'h01, t0);
        cyc(5);
        set_ttl(8'h00, t1);
        cyc(6);
        check("t4_count_before", 128'(bus.count), 128'(2));
        set_ttl(8'h01, t2);
        cyc(3);
        check("t4_valid_before", 128'(bus.valid), 128'(1));
        bus.read = 1'b1;
        cyc(1);
        bus.read = 1'b0;
        check("t4_count_same_edge", 128'(bus.count), 128'(2));
        pop_check("t4_pop1", word(t1, 8'h01, 8'h00));
        pop_check("t4_pop2", word(t2, 8'h01, 8'h01));

        // Flush with three stored entries.
        set_ttl(8'h00, ts);
        cyc(5);
        set_ttl(8'h01, ts);
        cyc(5);
        set_ttl(8'h00, ts);
        cyc(6);
        check("t5_count_before", 128'(bus.count), 128'(3));
        bus.flush = 1'b1;
        cyc(1);
        bus.flush = 1'b0;
        check("t5_count", 128'(bus.count), 128'(0));
        check("t5_valid", 128'(bus.valid), 128'(0));
        check("t5_empty", 128'(bus.empty), 128'(1));
        check("t5_ovf_data_kept", bus.overflow_error_data, ovf_word3);
        set_ttl(8'h01, ts);
        cyc(6);
        pop_check("t5_new_event", word(ts, 8'h01, 8'h01));

        // Reset while full and toggling, then edges while idle.
        o0 = ovf_seen;
        for (int i = 0; i < 4; i++) begin
            set_ttl((i % 2 == 0) ? 8'h00 : 8'h01, ts);
            cyc(5);
        end
        cyc(4);
        check("t6_count_before", 128'(bus.count), 128'(4));
        @(negedge clk);
        reset = 1'b0;
        bus.ttl_in = 8'h00;
        @(negedge clk);
        bus.ttl_in = 8'h01;
        @(negedge clk);
        check("t6_rst_dout", bus.dout, '0);
        check("t6_rst_valid", 128'(bus.valid), 128'(0));
        check("t6_rst_count", 128'(bus.count), 128'(0));
        check("t6_rst_empty", 128'(bus.empty), 128'(1));
        check("t6_rst_full", 128'(bus.full), 128'(0));
        check("t6_rst_ovf_data", bus.overflow_error_data, '0);
        bus.auto_start = 1'b0;
        bus.ttl_in = 8'h00;
        @(negedge clk);
        reset = 1'b1;
        set_ttl(8'h01, ts);
        cyc(5);
        set_ttl(8'h00, ts);
        cyc(5);
        set_ttl(8'h01, ts);
        cyc(6);
        check("t6_idle_count", 128'(bus.count), 128'(0));
        check("t6_idle_ovf", 128'(ovf_seen - o0), 128'(0));
        bus.auto_start = 1'b1;
        cyc(8);
        check("t6_enter_run_count", 128'(bus.count), 128'(0));
        set_ttl(8'h00, ts);
        cyc(6);
        pop_check("t6_run_event", word(ts, 8'h01, 8'h00));

        // Randomized traffic against the sample-level model.
        bus.rise_en = 8'($urandom);
        bus.fall_en = 8'($urandom);
        cyc(6);
        o0 = ovf_seen;
        mprev = bus.ttl_in;
        model_on = 1'b1;
        begin
            int n_ev = 0;
            int gap  = 3;
            for (int c = 0; c < 800; c++) begin
                @(negedge clk);
                if (n_ev < 60) begin
                    if (gap == 0) begin
                        bus.ttl_in = 8'($urandom);
                        n_ev++;
                        gap = int'($urandom_range(6, 12));
                    end else begin
                        gap--;
                    end
                end
                if (bus.read) begin
                    bus.read = 1'b0;
                end else if (bus.valid) begin
                    check("rand_model_has_word", 128'(mq.size() != 0), 128'(1));
                    if (mq.size() != 0) check("rand_word", bus.dout, mq.pop_front());
                    bus.read = 1'b1;
                end
            end
        end
        bus.read = 1'b0;
        cyc(2);
        check("rand_model_drained", 128'(mq.size()), 128'(0));
        check("rand_count_zero", 128'(bus.count), 128'(0));
        check("rand_no_overflow", 128'(ovf_seen - o0), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
